// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and field positions
// of the Status and Cause registers.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LO   = 8;
  localparam int STATUS_IM_HI   = 15;
  localparam int STATUS_BEV_BIT = 22;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI_BIT = 30;
  localparam int CAUSE_BD_BIT = 31;

  // Only address-error exceptions record a faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every COUNT_DIV clocks and TI latches
// on a Count==Compare match until Compare is rewritten.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] div;
  logic        tick;

  assign tick = (div == 32'(COUNT_DIV - 1));

  // A Count write restarts the prescaler so the new value is held a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      div     <= '0;
      ti      <= 1'b0;
    end else begin
      if (we_count) begin
        count <= wdata;
        div   <= '0;
      end else begin
        div <= tick ? '0 : div + 32'd1;
        if (tick) count <= count + 32'd1;
      end
      if (we_compare) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file and exception responder at the WB stage.
// Define CP0_TIMER_EN to include the Count/Compare timer (cp0_timer).
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = 32'hBFC0_0380,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stall,
  input  logic [31:0] wb_pc,
  input  logic        wb_cp0_ex,
  input  logic [4:0]  wb_cp0_excode,
  input  logic [31:0] wb_cp0_badvaddr,
  input  logic        wb_cp0_bd,
  input  logic        wb_cp0_eret_flush,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_addr,
  input  logic [31:0] wb_cp0_wdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_rdata,
  output logic        int_flush,
  output logic [31:0] flush_pc,
  output logic        int_pending,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc
);

  logic        ex, eret, eret_cmd, we_cmd;
  logic [7:0]  im;
  logic        ie, exl, bd;
  logic [1:0]  ip_sw;
  logic [5:0]  hw_q;
  logic [4:0]  exc_code;
  logic [31:0] epc, badvaddr;
  logic [7:0]  ip;
  logic        ti;

  assign ex       = wb_cp0_ex & ~wb_stall;
  assign eret     = wb_cp0_eret_flush & ~wb_stall;
  assign eret_cmd = eret & ~ex;
  assign we_cmd   = wb_cp0_we & ~wb_stall & ~ex & ~eret;

  assign int_flush   = ex | eret;
  assign flush_pc    = ex ? EX_ENTRY : epc;
  assign ip          = {hw_q[5] | ti, hw_q[4:0], ip_sw};
  assign int_pending = ie & ~exl & (|(ip & im));
  assign cp0_epc     = epc;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .we_count   (we_cmd && (wb_cp0_addr == REG_COUNT)),
    .we_compare (we_cmd && (wb_cp0_addr == REG_COMPARE)),
    .wdata      (wb_cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign ti = 1'b0;
`endif

  // A nested exception (EXL already set) keeps the original EPC and BD.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= STATUS_RESET[STATUS_IM_HI:STATUS_IM_LO];
      ie       <= 1'b0;
      exl      <= 1'b0;
      bd       <= 1'b0;
      ip_sw    <= '0;
      hw_q     <= '0;
      exc_code <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      hw_q <= hw_int;
      if (ex) begin
        if (!exl) begin
          epc <= wb_cp0_bd ? wb_pc - 32'd4 : wb_pc;
          bd  <= wb_cp0_bd;
        end
        exl      <= 1'b1;
        exc_code <= wb_cp0_excode;
        if (is_addr_exc(wb_cp0_excode)) badvaddr <= wb_cp0_badvaddr;
      end else if (eret_cmd) begin
        exl <= 1'b0;
      end else if (we_cmd) begin
        case (wb_cp0_addr)
          REG_STATUS: begin
            im  <= wb_cp0_wdata[STATUS_IM_HI:STATUS_IM_LO];
            exl <= wb_cp0_wdata[STATUS_EXL_BIT];
            ie  <= wb_cp0_wdata[STATUS_IE_BIT];
          end
          REG_CAUSE: ip_sw <= wb_cp0_wdata[CAUSE_IP_LO+1:CAUSE_IP_LO];
          REG_EPC:   epc   <= wb_cp0_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_status                              = '0;
    cp0_status[STATUS_BEV_BIT]              = 1'b1;
    cp0_status[STATUS_IM_HI:STATUS_IM_LO]   = im;
    cp0_status[STATUS_EXL_BIT]              = exl;
    cp0_status[STATUS_IE_BIT]               = ie;
    cp0_cause                               = '0;
    cp0_cause[CAUSE_BD_BIT]                 = bd;
    cp0_cause[CAUSE_TI_BIT]                 = ti;
    cp0_cause[CAUSE_IP_HI:CAUSE_IP_LO]      = ip;
    cp0_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]    = exc_code;
  end

  // mfc0 sees register contents before any same-cycle mtc0.
  always_comb begin
    cp0_rdata = '0;
    case (wb_cp0_addr)
      REG_BADVADDR: cp0_rdata = badvaddr;
`ifdef CP0_TIMER_EN
      REG_COUNT:    cp0_rdata = count;
      REG_COMPARE:  cp0_rdata = compare;
`endif
      REG_STATUS:   cp0_rdata = cp0_status;
      REG_CAUSE:    cp0_rdata = cp0_cause;
      REG_EPC:      cp0_rdata = epc;
      default:      cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed test-plan steps followed by random
// traffic, all compared against a behavioural CP0 model.
module tb_cp0_regs;

  localparam int          COUNT_DIV = 2;
  localparam logic [31:0] EX_ENTRY  = 32'hBFC0_0380;

  logic        clk;
  logic        reset;
  logic        wb_stall;
  logic [31:0] wb_pc;
  logic        wb_cp0_ex;
  logic [4:0]  wb_cp0_excode;
  logic [31:0] wb_cp0_badvaddr;
  logic        wb_cp0_bd;
  logic        wb_cp0_eret_flush;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_addr;
  logic [31:0] wb_cp0_wdata;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic        int_flush;
  logic [31:0] flush_pc;
  logic        int_pending;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state; Count is derived from the last written value and
  // the number of clocks elapsed since.
  bit [7:0]    m_im;
  bit          m_ie, m_exl, m_bd, m_ti;
  bit [5:0]    m_hw;
  bit [1:0]    m_ipsw;
  bit [4:0]    m_code;
  bit [31:0]   m_epc, m_badv, m_cbase, m_cmp;
  int unsigned m_cyc;

  cp0_regs #(.EX_ENTRY(EX_ENTRY), .COUNT_DIV(COUNT_DIV)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_stall          (wb_stall),
    .wb_pc             (wb_pc),
    .wb_cp0_ex         (wb_cp0_ex),
    .wb_cp0_excode     (wb_cp0_excode),
    .wb_cp0_badvaddr   (wb_cp0_badvaddr),
    .wb_cp0_bd         (wb_cp0_bd),
    .wb_cp0_eret_flush (wb_cp0_eret_flush),
    .wb_cp0_we         (wb_cp0_we),
    .wb_cp0_addr       (wb_cp0_addr),
    .wb_cp0_wdata      (wb_cp0_wdata),
    .hw_int            (hw_int),
    .cp0_rdata         (cp0_rdata),
    .int_flush         (int_flush),
    .flush_pc          (flush_pc),
    .int_pending       (int_pending),
    .cp0_status        (cp0_status),
    .cp0_cause         (cp0_cause),
    .cp0_epc           (cp0_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [31:0] mCount();
    return m_cbase + 32'(m_cyc / COUNT_DIV);
  endfunction

  function automatic bit [7:0] mIp();
    return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
  endfunction

  function automatic bit [31:0] mStatus();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic bit [31:0] mCause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(mIp()) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic bit mPending();
    return m_ie && !m_exl && ((mIp() & m_im) != 8'd0);
  endfunction

  function automatic bit [31:0] mRead(input bit [4:0] addr);
    case (addr)
      5'd8:  return m_badv;
`ifdef CP0_TIMER_EN
      5'd9:  return mCount();
      5'd11: return m_cmp;
`endif
      5'd12: return mStatus();
      5'd13: return mCause();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelUpdate();
    bit exq, erq, wq;
    exq = wb_cp0_ex & ~wb_stall;
    erq = wb_cp0_eret_flush & ~wb_stall & ~exq;
    wq  = wb_cp0_we & ~wb_stall & ~exq & ~erq;
    if (reset) begin
      m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_hw = 0; m_ipsw = 0;
      m_code = 0; m_epc = 0; m_badv = 0; m_cbase = 0; m_cmp = 0; m_cyc = 0;
      return;
    end
`ifdef CP0_TIMER_EN
    if (wq && wb_cp0_addr == 5'd11) m_ti = 0;
    else if (mCount() == m_cmp) m_ti = 1;
    if (wq && wb_cp0_addr == 5'd9) begin
      m_cbase = wb_cp0_wdata;
      m_cyc   = 0;
    end else begin
      m_cyc++;
    end
    if (wq && wb_cp0_addr == 5'd11) m_cmp = wb_cp0_wdata;
`endif
    m_hw = hw_int;
    if (exq) begin
      if (!m_exl) begin
        m_epc = wb_cp0_bd ? wb_pc - 4 : wb_pc;
        m_bd  = wb_cp0_bd;
      end
      m_exl  = 1;
      m_code = wb_cp0_excode;
      if (wb_cp0_excode == 5'd4 || wb_cp0_excode == 5'd5) m_badv = wb_cp0_badvaddr;
    end else if (erq) begin
      m_exl = 0;
    end else if (wq) begin
      if (wb_cp0_addr == 5'd12) begin
        m_im  = wb_cp0_wdata[15:8];
        m_exl = wb_cp0_wdata[1];
        m_ie  = wb_cp0_wdata[0];
      end else if (wb_cp0_addr == 5'd13) begin
        m_ipsw = wb_cp0_wdata[9:8];
      end else if (wb_cp0_addr == 5'd14) begin
        m_epc = wb_cp0_wdata;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    bit exq, erq;
    exq = wb_cp0_ex & ~wb_stall;
    erq = wb_cp0_eret_flush & ~wb_stall;
    checkOutput("int_flush", 32'(int_flush), 32'(exq | erq));
    checkOutput("flush_pc", flush_pc, exq ? EX_ENTRY : m_epc);
    checkOutput("int_pending", 32'(int_pending), 32'(mPending()));
    checkOutput("status", cp0_status, mStatus());
    checkOutput("cause", cp0_cause, mCause());
    checkOutput("epc", cp0_epc, m_epc);
    checkOutput("rdata", cp0_rdata, mRead(wb_cp0_addr));
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic ex,
                               input logic [4:0] code, input logic [31:0] pc,
                               input logic [31:0] bad, input logic bd, input logic eret,
                               input logic we, input logic [4:0] addr,
                               input logic [31:0] wd, input logic [5:0] hw);
    reset = rst; wb_stall = stall; wb_cp0_ex = ex; wb_cp0_excode = code;
    wb_pc = pc; wb_cp0_badvaddr = bad; wb_cp0_bd = bd; wb_cp0_eret_flush = eret;
    wb_cp0_we = we; wb_cp0_addr = addr; wb_cp0_wdata = wd; hw_int = hw;
  endtask

  task automatic stepCycle();
    #1;
    checkAll();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] addr, input logic [5:0] hw);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, addr, 0, hw);
    stepCycle();
  endtask

  task automatic doEx(input logic [4:0] code, input logic [31:0] pc,
                      input logic [31:0] bad, input logic bd);
    applyStimulus(0, 0, 1, code, pc, bad, bd, 0, 0, 5'd14, 0, 0);
    stepCycle();
  endtask

  task automatic doWrite(input logic [4:0] addr, input logic [31:0] wd, input logic [5:0] hw);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, addr, wd, hw);
    stepCycle();
  endtask

  initial begin
    logic [4:0] addrs [8];
    logic [4:0] codes [7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0);
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    stepCycle();
    checkOutput("reset_status", cp0_status, 32'h0040_0000);
    checkOutput("reset_cause", cp0_cause, 32'h0);
    checkOutput("reset_epc", cp0_epc, 32'h0);
    checkOutput("reset_pending", 32'(int_pending), 32'h0);
    checkOutput("reset_flush", 32'(int_flush), 32'h0);

    $display("[TB] syscall exception");
    applyStimulus(0, 0, 1, 5'd8, 32'hBFC0_1000, 0, 0, 0, 0, 5'd14, 0, 0);
    #1;
    checkOutput("sys_flush", 32'(int_flush), 32'h1);
    checkOutput("sys_flush_pc", flush_pc, 32'hBFC0_0380);
    stepCycle();
    idle(5'd13, 0);
    checkOutput("sys_epc", cp0_epc, 32'hBFC0_1000);
    checkOutput("sys_exl", 32'(cp0_status[1]), 32'h1);
    checkOutput("sys_excode", 32'(cp0_cause[6:2]), 32'd8);

    $display("[TB] eret and stalled eret");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 5'd12, 0, 0);
    #1;
    checkOutput("stalled_eret_flush", 32'(int_flush), 32'h0);
    stepCycle();
    checkOutput("stalled_eret_exl", 32'(cp0_status[1]), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd12, 0, 0);
    #1;
    checkOutput("eret_flush", 32'(int_flush), 32'h1);
    checkOutput("eret_flush_pc", flush_pc, 32'hBFC0_1000);
    stepCycle();
    checkOutput("eret_exl", 32'(cp0_status[1]), 32'h0);

    $display("[TB] delay-slot AdEL and nested exception");
    doEx(5'd4, 32'hBFC0_1004, 32'h0000_0003, 1);
    idle(5'd8, 0);
    checkOutput("adel_epc", cp0_epc, 32'hBFC0_1000);
    checkOutput("adel_bd", 32'(cp0_cause[31]), 32'h1);
    checkOutput("adel_badvaddr", cp0_rdata, 32'h0000_0003);
    doEx(5'd10, 32'hBFC0_2000, 32'hDEAD_BEEF, 0);
    idle(5'd8, 0);
    checkOutput("nested_epc", cp0_epc, 32'hBFC0_1000);
    checkOutput("nested_excode", 32'(cp0_cause[6:2]), 32'd10);
    checkOutput("nested_badvaddr", cp0_rdata, 32'h0000_0003);

    $display("[TB] timer interrupt");
    doWrite(5'd12, 32'h0000_8001, 0);
    doWrite(5'd9, 32'd0, 0);
    doWrite(5'd11, 32'd4, 0);
    for (int i = 0; i < 12; i++) idle(5'd9, 0);
`ifdef CP0_TIMER_EN
    checkOutput("timer_ti", 32'(cp0_cause[30]), 32'h1);
    checkOutput("timer_pending", 32'(int_pending), 32'h1);
    doWrite(5'd11, 32'd100, 0);
    checkOutput("compare_clears_ti", 32'(cp0_cause[30]), 32'h0);
    checkOutput("compare_clears_pending", 32'(int_pending), 32'h0);
`else
    checkOutput("count_reads_zero", cp0_rdata, 32'h0);
    checkOutput("no_timer_pending", 32'(int_pending), 32'h0);
`endif

    $display("[TB] mtc0 discarded by exception, then hardware interrupt");
    applyStimulus(0, 0, 1, 5'd12, 32'hBFC0_3000, 0, 0, 0, 1, 5'd12, 32'h0000_0401, 0);
    stepCycle();
    checkOutput("discard_status", cp0_status, 32'h0040_8003);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd12, 0, 0);
    stepCycle();
    doWrite(5'd12, 32'h0000_0401, 6'b000001);
    idle(5'd13, 6'b000001);
    checkOutput("hw_ip2", 32'(cp0_cause[10]), 32'h1);
    checkOutput("hw_pending", 32'(int_pending), 32'h1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                    codes[$urandom % 7], $urandom, $urandom, $urandom % 2,
                    ($urandom % 8) == 0, $urandom % 2, addrs[$urandom % 8],
                    (($urandom % 4) == 0) ? 32'($urandom % 16) : $urandom,
                    6'($urandom));
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
